// File: rtl/servo_seg_sched.sv
// Segment scheduler: takes one multi-axis Nx segment per handshake and strobes it into
// every axis buffer with a shared WR pulse, avoiding full buffers and T-period boundaries.
module servo_seg_sched #(
    parameter int NAXIS   = 2,
    parameter int NW      = 8,
    parameter int WR_HIGH = 2,
    parameter int WR_GAP  = 2,
    parameter int T_GUARD = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                seg_valid,
    output logic                seg_ready,
    input  logic [NAXIS*NW-1:0] seg_nx,
    input  logic                abort,
    input  logic                ls_in,
    input  logic                halt_clr,
    input  logic [NAXIS-1:0]    flag_full_i,
    input  logic [NAXIS-1:0]    flag_T_i,
    output logic [NAXIS*NW-1:0] nx_o,
    output logic                wr_o,
    output logic                ls_o,
    output logic                halted,
    output logic [15:0]         seg_count
);

    localparam int GW = $clog2(T_GUARD + 1);
    localparam int CW = $clog2(WR_HIGH + WR_GAP + 1);

    typedef enum logic [2:0] {IDLE, SETUP, WR_HI, WR_LO, HALT} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [GW-1:0]  guard, guard_nxt;
    logic [NAXIS-1:0] t_prev;
    logic           toggle, stop, full, hs, load, inc, ready_nxt;

    // NOTE: every variable written here gets a default first, so no latches are inferred.
    always_comb begin
        toggle    = |(flag_T_i ^ t_prev);
        stop      = ls_in | abort;
        full      = |flag_full_i;
        hs        = seg_valid & seg_ready;
        guard_nxt = toggle ? GW'(T_GUARD) : ((guard != '0) ? guard - 1'b1 : '0);
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        inc       = 1'b0;
        case (state)
            IDLE: begin
                if (stop) state_nxt = HALT;
                else if (hs) begin
                    state_nxt = SETUP;
                    load      = 1'b1;
                end
            end
            SETUP: begin
                // The live toggle term covers a T flip landing on the would-be WR rising edge.
                if (stop) state_nxt = HALT;
                else if (guard == '0 && !toggle && !full) begin
                    state_nxt = WR_HI;
                    cnt_nxt   = CW'(WR_HIGH - 1);
                    inc       = 1'b1;
                end
            end
            WR_HI: begin
                if (stop) state_nxt = HALT;
                else if (cnt == '0) begin
                    state_nxt = WR_LO;
                    cnt_nxt   = CW'(WR_GAP - 1);
                end else cnt_nxt = cnt - 1'b1;
            end
            WR_LO: begin
                if (stop) state_nxt = HALT;
                else if (cnt == '0) state_nxt = IDLE;
                else cnt_nxt = cnt - 1'b1;
            end
            HALT: begin
                if (halt_clr && !stop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        ready_nxt = (state_nxt == IDLE) && !full && (guard_nxt == '0) && !stop;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            guard     <= '0;
            t_prev    <= '0;
            seg_ready <= 1'b0;
            nx_o      <= '0;
            wr_o      <= 1'b0;
            ls_o      <= 1'b0;
            halted    <= 1'b0;
            seg_count <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            guard     <= guard_nxt;
            t_prev    <= flag_T_i;
            seg_ready <= ready_nxt;
            wr_o      <= (state_nxt == WR_HI);
            ls_o      <= (state_nxt == HALT);
            halted    <= (state_nxt == HALT);
            if (load) nx_o <= seg_nx;
            if (inc && seg_count != 16'hFFFF) seg_count <= seg_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_servo_seg_sched.sv
// Self-checking bench for servo_seg_sched: behavioural reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_servo_seg_sched;

    localparam int NAXIS = 2, NW = 8, WR_HIGH = 2, WR_GAP = 2, T_GUARD = 3;

    logic clk = 0, rst_n = 0;
    logic seg_valid = 0, abort = 0, ls_in = 0, halt_clr = 0;
    logic [NAXIS*NW-1:0] seg_nx = '0;
    logic [NAXIS-1:0] flag_full_i = '0, flag_T_i = '0;
    logic seg_ready, wr_o, ls_o, halted;
    logic [NAXIS*NW-1:0] nx_o;
    logic [15:0] seg_count;

    int tests_run = 0, tests_failed = 0;

    servo_seg_sched #(.NAXIS(NAXIS), .NW(NW), .WR_HIGH(WR_HIGH), .WR_GAP(WR_GAP),
                      .T_GUARD(T_GUARD)) dut (
        .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .seg_nx(seg_nx), .abort(abort), .ls_in(ls_in), .halt_clr(halt_clr),
        .flag_full_i(flag_full_i), .flag_T_i(flag_T_i), .nx_o(nx_o), .wr_o(wr_o),
        .ls_o(ls_o), .halted(halted), .seg_count(seg_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: segment lifecycle expressed as phases with remaining-cycle budgets.
    localparam int P_IDLE = 0, P_WAIT = 1, P_STROBE = 2, P_GAP = 3, P_HALT = 4;
    int m_phase, m_left, m_guard;
    logic [NAXIS-1:0] m_tprev;
    logic m_edge_toggle;
    logic e_ready, e_wr, e_ls, e_halt;
    logic [NAXIS*NW-1:0] e_nx;
    logic [15:0] e_count;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_left = 0; m_guard = 0; m_tprev = '0; m_edge_toggle = 0;
            e_ready = 0; e_wr = 0; e_ls = 0; e_halt = 0; e_nx = '0; e_count = 0;
        end else begin
            automatic bit tgl   = (flag_T_i != m_tprev);
            automatic bit stopr = ls_in || abort;
            automatic bit busy  = (flag_full_i != '0);
            automatic bit took  = seg_valid && e_ready;
            automatic int g_new = tgl ? T_GUARD : (m_guard > 0 ? m_guard - 1 : 0);
            if (m_phase == P_HALT) begin
                if (halt_clr && !stopr) m_phase = P_IDLE;
            end else if (stopr) begin
                m_phase = P_HALT;
            end else if (m_phase == P_IDLE) begin
                if (took) begin e_nx = seg_nx; m_phase = P_WAIT; end
            end else if (m_phase == P_WAIT) begin
                if (m_guard == 0 && !tgl && !busy) begin
                    m_phase = P_STROBE; m_left = WR_HIGH;
                    if (e_count != 16'hFFFF) e_count = e_count + 1;
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_phase == P_STROBE) begin m_phase = P_GAP; m_left = WR_GAP; end
                    else m_phase = P_IDLE;
                end
            end
            m_edge_toggle = tgl;
            m_guard = g_new;
            m_tprev = flag_T_i;
            e_wr    = (m_phase == P_STROBE);
            e_ls    = (m_phase == P_HALT);
            e_halt  = (m_phase == P_HALT);
            e_ready = (m_phase == P_IDLE) && !busy && (g_new == 0) && !stopr;
        end
    end

    logic wr_last = 0;
    always @(negedge clk) begin
        check("seg_ready", 32'(seg_ready), 32'(e_ready));
        check("wr_o", 32'(wr_o), 32'(e_wr));
        check("ls_o", 32'(ls_o), 32'(e_ls));
        check("halted", 32'(halted), 32'(e_halt));
        check("nx_o", 32'(nx_o), 32'(e_nx));
        check("seg_count", 32'(seg_count), 32'(e_count));
        if (wr_o && !wr_last) check("wr_rise_on_T_toggle", 32'(m_edge_toggle), 32'd0);
        wr_last = wr_o;
    end

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!seg_ready && n < budget) begin @(negedge clk); n++; end
        if (!seg_ready) check("ready_timeout", 32'(seg_ready), 32'd1);
    endtask

    task automatic wait_wr_rise(input int budget);
        int n = 0;
        while (!wr_o && n < budget) begin @(negedge clk); n++; end
        if (!wr_o) check("wr_timeout", 32'(wr_o), 32'd1);
    endtask

    task automatic send_seg(input logic [15:0] data);
        wait_ready(30);
        seg_nx = data; seg_valid = 1;
        @(negedge clk);
        seg_valid = 0;
    endtask

    initial begin
        int nlow;
        logic [15:0] cnt_before;
        #2;
        check("rst_wr", 32'(wr_o), 32'd0);
        check("rst_ready", 32'(seg_ready), 32'd0);
        check("rst_count", 32'(seg_count), 32'd0);
        check("rst_nx", 32'(nx_o), 32'd0);
        @(negedge clk); rst_n = 1;

        // Basic write: data one cycle ahead of WR, WR high exactly two cycles.
        wait_ready(10);
        seg_nx = 16'h8305; seg_valid = 1;
        @(negedge clk); seg_valid = 0;
        check("t1_nx_setup", 32'(nx_o), 32'h8305);
        check("t1_wr_low_setup", 32'(wr_o), 32'd0);
        @(negedge clk);
        check("t1_wr_hi1", 32'(wr_o), 32'd1);
        check("t1_count", 32'(seg_count), 32'd1);
        @(negedge clk);
        check("t1_wr_hi2", 32'(wr_o), 32'd1);
        @(negedge clk);
        check("t1_wr_fall", 32'(wr_o), 32'd0);

        // Full buffer blocks the handshake; release lets the write through quickly.
        wait_ready(10);
        flag_full_i = 2'b01;
        @(negedge clk); seg_valid = 1; seg_nx = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_ready_blocked", 32'(seg_ready), 32'd0);
            check("t2_wr_blocked", 32'(wr_o), 32'd0);
        end
        flag_full_i = 2'b00;
        wait_wr_rise(4);
        seg_valid = 0;

        // T toggle during SETUP pushes the WR rise out by the guard window.
        wait_ready(20);
        seg_nx = 16'h0A7F; seg_valid = 1;
        @(negedge clk); seg_valid = 0;
        flag_T_i[1] = ~flag_T_i[1];
        nlow = 0;
        while (!wr_o && nlow < 10) begin @(negedge clk); if (!wr_o) nlow++; end
        check("t3_guard_delay", 32'(nlow), 32'd4);

        // Limit switch mid-strobe: immediate halt, clear ignored while switch active.
        send_seg(16'h55AA);
        wait_wr_rise(10);
        ls_in = 1;
        @(negedge clk);
        check("t4_wr_drop", 32'(wr_o), 32'd0);
        check("t4_ls", 32'(ls_o), 32'd1);
        check("t4_halted", 32'(halted), 32'd1);
        halt_clr = 1; @(negedge clk); halt_clr = 0; @(negedge clk);
        check("t4_clr_ignored", 32'(halted), 32'd1);
        ls_in = 0; @(negedge clk);
        halt_clr = 1; @(negedge clk); halt_clr = 0;
        check("t4_halt_exit", 32'(halted), 32'd0);
        check("t4_ls_exit", 32'(ls_o), 32'd0);

        // Abort coincident with a handshake: segment refused, count untouched.
        wait_ready(20);
        cnt_before = seg_count;
        seg_nx = 16'hBEEF; seg_valid = 1; abort = 1;
        @(negedge clk); seg_valid = 0;
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_count", 32'(seg_count), 32'(cnt_before));
        abort = 0; @(negedge clk);
        halt_clr = 1; @(negedge clk); halt_clr = 0;

        // Count saturation, then asynchronous reset in the middle of a strobe.
        wait_ready(20);
        force dut.seg_count = 16'hFFFE;
        e_count = 16'hFFFE;
        @(negedge clk);
        release dut.seg_count;
        for (int i = 0; i < 3; i++) begin
            send_seg(16'(i * 16'h0111));
            wait_wr_rise(10);
        end
        check("t6_saturate", 32'(seg_count), 32'hFFFF);
        send_seg(16'h7777);
        wait_wr_rise(10);
        #2 rst_n = 0;
        #1;
        check("t6_rst_wr", 32'(wr_o), 32'd0);
        check("t6_rst_count", 32'(seg_count), 32'd0);
        check("t6_rst_nx", 32'(nx_o), 32'd0);
        check("t6_rst_ls", 32'(ls_o), 32'd0);
        @(negedge clk); rst_n = 1;

        // Randomized soak against the model.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            seg_valid   = ($urandom_range(0, 99) < 70);
            seg_nx      = 16'($urandom);
            flag_full_i = 2'($urandom_range(0, 99) < 12 ? $urandom_range(1, 3) : 0);
            if ($urandom_range(0, 99) < 8) flag_T_i[0] = ~flag_T_i[0];
            if ($urandom_range(0, 99) < 8) flag_T_i[1] = ~flag_T_i[1];
            ls_in    = ($urandom_range(0, 99) < 2);
            abort    = ($urandom_range(0, 99) < 2);
            halt_clr = ($urandom_range(0, 99) < 25);
        end
        seg_valid = 0; ls_in = 0; abort = 0; halt_clr = 0; flag_full_i = '0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
